// File: rtl/multi_score_tracker.sv
// multi_score_tracker: whack-a-mole round controller and scorer.
// Tracks which moles are up, converts switch rising edges into hits/misses,
// and maintains score (with streak bonus), streak and miss counters.
// Optional feature: define SCORE_MISS_PENALTY_EN to make misses subtract
// from the score and break the streak.
module multi_score_tracker #(
  parameter int NUM_HOLES    = 8,
  parameter int SCORE_W      = 8,
  parameter int STREAK_W     = 4,
  parameter int BONUS_THRESH = 3
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 gamestart,
  input  logic                 gameend,
  input  logic [NUM_HOLES-1:0] input_pos,
  input  logic [NUM_HOLES-1:0] switch_hit,
  output logic [NUM_HOLES-1:0] cmole,
  output logic [NUM_HOLES-1:0] molehit,
  output logic [SCORE_W-1:0]   score,
  output logic [STREAK_W-1:0]  streak,
  output logic [SCORE_W-1:0]   misses,
  output logic [1:0]           game_state
);

  // Width of a per-cycle hit/miss count.
  localparam int CNT_W      = $clog2(NUM_HOLES + 1);
  // Score update is formed two bits wider so bonus additions cannot wrap.
  localparam int SUM_W      = SCORE_W + 2;
  localparam int STK_SUM_W  = ((STREAK_W > CNT_W) ? STREAK_W : CNT_W) + 1;
  localparam int MISS_SUM_W = SCORE_W + 1;

  localparam logic [SUM_W-1:0]      SCORE_MAX_EXT  = {2'b00, {SCORE_W{1'b1}}};
  localparam logic [STK_SUM_W-1:0]  STREAK_MAX_EXT = {{(STK_SUM_W-STREAK_W){1'b0}}, {STREAK_W{1'b1}}};
  localparam logic [MISS_SUM_W-1:0] MISSES_MAX_EXT = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [STREAK_W-1:0]   BONUS_TH       = STREAK_W'(BONUS_THRESH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Number of set bits in a hole vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic [NUM_HOLES-1:0]  r_cmole;
  logic [NUM_HOLES-1:0]  r_molehit;
  logic [SCORE_W-1:0]    r_score;
  logic [STREAK_W-1:0]   r_streak;
  logic [SCORE_W-1:0]    r_misses;
  logic [NUM_HOLES-1:0]  r_sw_prev;

  logic [NUM_HOLES-1:0]  w_rise;
  logic [NUM_HOLES-1:0]  w_hits;
  logic [NUM_HOLES-1:0]  w_miss;
  logic [CNT_W-1:0]      w_hit_cnt;
  logic [CNT_W-1:0]      w_miss_cnt;
  logic [CNT_W-1:0]      w_bonus;
  logic [SUM_W-1:0]      w_score_gain;
  logic [SUM_W-1:0]      w_score_net;
  logic [SCORE_W-1:0]    w_score_clamped;
  logic [STREAK_W-1:0]   w_streak_base;
  logic [STK_SUM_W-1:0]  w_streak_sum;
  logic [STREAK_W-1:0]   w_streak_sat;
  logic [MISS_SUM_W-1:0] w_misses_sum;
  logic [SCORE_W-1:0]    w_misses_sat;

  logic [NUM_HOLES-1:0]  w_cmole_n;
  logic [NUM_HOLES-1:0]  w_molehit_n;
  logic [SCORE_W-1:0]    w_score_n;
  logic [STREAK_W-1:0]   w_streak_n;
  logic [SCORE_W-1:0]    w_misses_n;

  // Only a fresh press counts; a held switch has its previous level set.
  assign w_rise     = switch_hit & ~r_sw_prev;
  assign w_hits     = w_rise & r_cmole;
  assign w_miss     = w_rise & ~r_cmole;
  assign w_hit_cnt  = popcount(w_hits);
  assign w_miss_cnt = popcount(w_miss);
  // Every hit is doubled once the streak (before this update) is hot.
  assign w_bonus    = (r_streak >= BONUS_TH) ? w_hit_cnt : {CNT_W{1'b0}};

  assign w_score_gain = SUM_W'(r_score) + SUM_W'(w_hit_cnt) + SUM_W'(w_bonus);

`ifdef SCORE_MISS_PENALTY_EN
  // Misses are netted against this cycle's gain, floored at zero.
  assign w_score_net   = (w_score_gain >= SUM_W'(w_miss_cnt)) ?
                         (w_score_gain - SUM_W'(w_miss_cnt)) : {SUM_W{1'b0}};
  // Any miss breaks the streak; same-cycle hits start a new one.
  assign w_streak_base = (w_miss_cnt != {CNT_W{1'b0}}) ? {STREAK_W{1'b0}} : r_streak;
`else
  assign w_score_net   = w_score_gain;
  assign w_streak_base = r_streak;
`endif

  assign w_score_clamped = (w_score_net > SCORE_MAX_EXT) ? {SCORE_W{1'b1}} : w_score_net[SCORE_W-1:0];
  assign w_streak_sum    = STK_SUM_W'(w_streak_base) + STK_SUM_W'(w_hit_cnt);
  assign w_streak_sat    = (w_streak_sum > STREAK_MAX_EXT) ? {STREAK_W{1'b1}} : w_streak_sum[STREAK_W-1:0];
  assign w_misses_sum    = MISS_SUM_W'(r_misses) + MISS_SUM_W'(w_miss_cnt);
  assign w_misses_sat    = (w_misses_sum > MISSES_MAX_EXT) ? {SCORE_W{1'b1}} : w_misses_sum[SCORE_W-1:0];

  // Game state register; reset overrides every other input.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next game state; dropping gamestart wins over gameend.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (gamestart) w_next_state = ST_PLAY;
        else           w_next_state = ST_IDLE;
      end
      ST_PLAY: begin
        if (!gamestart)   w_next_state = ST_IDLE;
        else if (gameend) w_next_state = ST_DONE;
        else              w_next_state = ST_PLAY;
      end
      ST_DONE: begin
        if (!gamestart) w_next_state = ST_IDLE;
        else            w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the board and counters for the current state.
  always_comb begin
    w_cmole_n   = r_cmole;
    w_molehit_n = {NUM_HOLES{1'b0}};
    w_score_n   = r_score;
    w_streak_n  = r_streak;
    w_misses_n  = r_misses;
    case (r_state)
      ST_IDLE: begin
        w_cmole_n = {NUM_HOLES{1'b0}};
        if (w_next_state == ST_PLAY) begin
          w_score_n  = {SCORE_W{1'b0}};
          w_streak_n = {STREAK_W{1'b0}};
          w_misses_n = {SCORE_W{1'b0}};
        end else begin
          w_score_n  = r_score;
          w_streak_n = r_streak;
          w_misses_n = r_misses;
        end
      end
      ST_PLAY: begin
        if (w_next_state != ST_PLAY) begin
          // Leaving play: board goes dark, counters freeze.
          w_cmole_n = {NUM_HOLES{1'b0}};
        end else if (enable) begin
          // New pattern; presses this cycle are discarded.
          w_cmole_n = input_pos;
          if (r_cmole != {NUM_HOLES{1'b0}}) w_streak_n = {STREAK_W{1'b0}};
          else                              w_streak_n = r_streak;
        end else begin
          w_cmole_n   = r_cmole & ~w_hits;
          w_molehit_n = w_hits;
          w_score_n   = w_score_clamped;
          w_streak_n  = w_streak_sat;
          w_misses_n  = w_misses_sat;
        end
      end
      ST_DONE: begin
        w_cmole_n = {NUM_HOLES{1'b0}};
      end
      default: begin
        w_cmole_n = {NUM_HOLES{1'b0}};
      end
    endcase
  end

  // Board, counters and switch history registers.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_cmole   <= {NUM_HOLES{1'b0}};
      r_molehit <= {NUM_HOLES{1'b0}};
      r_score   <= {SCORE_W{1'b0}};
      r_streak  <= {STREAK_W{1'b0}};
      r_misses  <= {SCORE_W{1'b0}};
      r_sw_prev <= {NUM_HOLES{1'b1}};
    end else begin
      r_cmole   <= w_cmole_n;
      r_molehit <= w_molehit_n;
      r_score   <= w_score_n;
      r_streak  <= w_streak_n;
      r_misses  <= w_misses_n;
      r_sw_prev <= switch_hit;
    end
  end

  assign cmole      = r_cmole;
  assign molehit    = r_molehit;
  assign score      = r_score;
  assign streak     = r_streak;
  assign misses     = r_misses;
  assign game_state = r_state;

endmodule

// File: tb/tb_multi_score_tracker.sv
// Self-checking bench for multi_score_tracker (default parameters).
module tb_multi_score_tracker;
  logic       clk = 1'b0;
  logic       reset, enable, gamestart, gameend;
  logic [7:0] input_pos, switch_hit;
  logic [7:0] cmole, molehit, score, misses;
  logic [3:0] streak;
  logic [1:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [1:0] m_state;
  logic [7:0] m_cmole, m_molehit, m_prev;
  int         m_score, m_streak, m_misses;

  multi_score_tracker dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .enable    (enable),
    .gamestart (gamestart),
    .gameend   (gameend),
    .input_pos (input_pos),
    .switch_hit(switch_hit),
    .cmole     (cmole),
    .molehit   (molehit),
    .score     (score),
    .streak    (streak),
    .misses    (misses),
    .game_state(game_state)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Behavioural model: one call per clock edge, using the current inputs.
  task automatic model_step();
    logic [7:0] rise, hits, miss;
    int h, m, s;
    if (reset) begin
      m_state = 2'b00; m_cmole = 8'h00; m_molehit = 8'h00; m_prev = 8'hFF;
      m_score = 0; m_streak = 0; m_misses = 0;
    end else begin
      rise = switch_hit & ~m_prev;
      m_prev = switch_hit;
      m_molehit = 8'h00;
      if (m_state == 2'b00) begin
        m_cmole = 8'h00;
        if (gamestart) begin
          m_state = 2'b01; m_score = 0; m_streak = 0; m_misses = 0;
        end
      end else if (m_state == 2'b01) begin
        if (!gamestart) begin
          m_state = 2'b00; m_cmole = 8'h00;
        end else if (gameend) begin
          m_state = 2'b10; m_cmole = 8'h00;
        end else if (enable) begin
          if (m_cmole != 8'h00) m_streak = 0;
          m_cmole = input_pos;
        end else begin
          hits = rise & m_cmole;
          miss = rise & ~m_cmole;
          h = $countones(hits);
          m = $countones(miss);
          s = m_score + h + ((m_streak >= 3) ? h : 0);
`ifdef SCORE_MISS_PENALTY_EN
          s = s - m;
          m_streak = (m > 0) ? clampi(h, 0, 15) : clampi(m_streak + h, 0, 15);
`else
          m_streak = clampi(m_streak + h, 0, 15);
`endif
          m_score   = clampi(s, 0, 255);
          m_misses  = clampi(m_misses + m, 0, 255);
          m_cmole   = m_cmole & ~hits;
          m_molehit = hits;
        end
      end else begin
        m_cmole = 8'h00;
        if (!gamestart) m_state = 2'b00;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_game();
    gamestart = 1'b0; gameend = 1'b0; enable = 1'b0; switch_hit = 8'h00; input_pos = 8'h00;
    tick();
    gamestart = 1'b1;
    tick();
  endtask

  task automatic load(input logic [7:0] p);
    enable = 1'b1; input_pos = p;
    tick();
    enable = 1'b0; input_pos = 8'h00;
  endtask

  task automatic press(input logic [7:0] p);
    switch_hit = p;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; gamestart = 1'b1; gameend = 1'b0; enable = 1'b1;
    input_pos = 8'hFF; switch_hit = 8'h00;
    tick(); tick();
    n_checks++; if (game_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: actual %b expected 00", game_state); end
    n_checks++; if (cmole !== 8'h00) begin n_fail++; $display("FAIL reset_cmole: actual %h expected 00", cmole); end
    n_checks++; if (molehit !== 8'h00) begin n_fail++; $display("FAIL reset_molehit: actual %h expected 00", molehit); end
    n_checks++; if (score !== 8'd0 || streak !== 4'd0 || misses !== 8'd0) begin
      n_fail++; $display("FAIL reset_counters: actual %0d/%0d/%0d expected 0/0/0", score, streak, misses); end
    reset = 1'b0; enable = 1'b0; input_pos = 8'h00; gamestart = 1'b0;
    tick();
  endtask

  task automatic test_single_hit();
    new_game();
    n_checks++; if (game_state !== 2'b01) begin n_fail++; $display("FAIL start_state: actual %b expected 01", game_state); end
    load(8'h24);
    n_checks++; if (cmole !== 8'h24) begin n_fail++; $display("FAIL load_cmole: actual %h expected 24", cmole); end
    press(8'h04);
    n_checks++; if (molehit !== 8'h04) begin n_fail++; $display("FAIL hit1_molehit: actual %h expected 04", molehit); end
    n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL hit1_score: actual %0d expected 1", score); end
    n_checks++; if (cmole !== 8'h20) begin n_fail++; $display("FAIL hit1_cmole: actual %h expected 20", cmole); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (molehit !== 8'h00 || score !== 8'd1) begin
        n_fail++; $display("FAIL hold_no_rescore: cycle %0d actual molehit %h score %0d expected 00 1", i, molehit, score); end
    end
  endtask

  task automatic test_double_hit();
    press(8'h00);
    load(8'h24);
    n_checks++; if (streak !== 4'd0) begin n_fail++; $display("FAIL escape_streak: actual %0d expected 0", streak); end
    press(8'h24);
    n_checks++; if (molehit !== 8'h24) begin n_fail++; $display("FAIL dbl_molehit: actual %h expected 24", molehit); end
    n_checks++; if (score !== 8'd3) begin n_fail++; $display("FAIL dbl_score: actual %0d expected 3", score); end
    n_checks++; if (cmole !== 8'h00 || streak !== 4'd2) begin
      n_fail++; $display("FAIL dbl_cmole_streak: actual %h/%0d expected 00/2", cmole, streak); end
  endtask

  task automatic test_bonus();
    new_game();
    load(8'hFF); press(8'h7F); press(8'h00);
    load(8'h07);
    n_checks++; if (score !== 8'd7 || streak !== 4'd0) begin
      n_fail++; $display("FAIL bonus_setup: actual %0d/%0d expected 7/0", score, streak); end
    press(8'h07);
    n_checks++; if (score !== 8'd10 || streak !== 4'd3) begin
      n_fail++; $display("FAIL bonus_pre: actual %0d/%0d expected 10/3", score, streak); end
    press(8'h00); load(8'h01);
    press(8'h01);
    n_checks++; if (score !== 8'd12 || streak !== 4'd4) begin
      n_fail++; $display("FAIL bonus_hit: actual %0d/%0d expected 12/4", score, streak); end
    press(8'h00); load(8'h01);
    n_checks++; if (streak !== 4'd4) begin n_fail++; $display("FAIL empty_enable_streak: actual %0d expected 4", streak); end
    load(8'h02);
    n_checks++; if (streak !== 4'd0 || cmole !== 8'h02) begin
      n_fail++; $display("FAIL escape_clear: actual %0d/%h expected 0/02", streak, cmole); end
  endtask

  task automatic test_miss();
    new_game();
    press(8'h01);
    n_checks++; if (misses !== 8'd1 || score !== 8'd0 || streak !== 4'd0 || molehit !== 8'h00) begin
      n_fail++; $display("FAIL miss_empty: actual %0d/%0d/%0d/%h expected 1/0/0/00", misses, score, streak, molehit); end
    press(8'h00); load(8'h02); press(8'h02); press(8'h00);
    press(8'h01);
    n_checks++; if (misses !== 8'd2) begin n_fail++; $display("FAIL miss_count: actual %0d expected 2", misses); end
`ifdef SCORE_MISS_PENALTY_EN
    n_checks++; if (score !== 8'd0 || streak !== 4'd0) begin
      n_fail++; $display("FAIL miss_penalty: actual %0d/%0d expected 0/0", score, streak); end
`else
    n_checks++; if (score !== 8'd1 || streak !== 4'd1) begin
      n_fail++; $display("FAIL miss_nopenalty: actual %0d/%0d expected 1/1", score, streak); end
`endif
  endtask

  task automatic test_saturate();
    new_game();
    for (int i = 0; i < 16; i++) begin
      load(8'hFF); press(8'hFF); press(8'h00);
    end
    n_checks++; if (score !== 8'd248 || streak !== 4'd15) begin
      n_fail++; $display("FAIL sat_build: actual %0d/%0d expected 248/15", score, streak); end
    load(8'h07); press(8'h07);
    n_checks++; if (score !== 8'd254) begin n_fail++; $display("FAIL sat_254: actual %0d expected 254", score); end
    press(8'h00); load(8'h03); press(8'h03);
    n_checks++; if (score !== 8'd255 || molehit !== 8'h03) begin
      n_fail++; $display("FAIL sat_255: actual %0d/%h expected 255/03", score, molehit); end
    press(8'h00); load(8'h0C);
    gameend = 1'b1;
    tick();
    n_checks++; if (game_state !== 2'b10 || cmole !== 8'h00) begin
      n_fail++; $display("FAIL done_enter: actual %b/%h expected 10/00", game_state, cmole); end
    gameend = 1'b0;
    press(8'h0C);
    n_checks++; if (molehit !== 8'h00 || score !== 8'd255 || misses !== 8'd0) begin
      n_fail++; $display("FAIL done_ignore: actual %h/%0d/%0d expected 00/255/0", molehit, score, misses); end
    load(8'hFF);
    n_checks++; if (cmole !== 8'h00 || game_state !== 2'b10) begin
      n_fail++; $display("FAIL done_enable: actual %h/%b expected 00/10", cmole, game_state); end
  endtask

  task automatic test_reset_mid();
    new_game();
    load(8'h1F); press(8'h1F);
    n_checks++; if (score !== 8'd5) begin n_fail++; $display("FAIL mid_setup: actual %0d expected 5", score); end
    load(8'h01);
    reset = 1'b1;
    tick();
    n_checks++; if (game_state !== 2'b00 || cmole !== 8'h00 || molehit !== 8'h00 ||
                    score !== 8'd0 || streak !== 4'd0 || misses !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset: actual %b/%h/%h/%0d/%0d/%0d expected all 0",
                         game_state, cmole, molehit, score, streak, misses); end
    reset = 1'b0;
    tick();
    load(8'h1F);
    tick();
    n_checks++; if (molehit !== 8'h00 || score !== 8'd0 || misses !== 8'd0 || cmole !== 8'h1F) begin
      n_fail++; $display("FAIL held_after_reset: actual %h/%0d/%0d/%h expected 00/0/0/1F", molehit, score, misses, cmole); end
  endtask

  task automatic test_random();
    new_game();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      gamestart = ($urandom_range(0, 49) != 0);
      gameend   = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 3) == 0);
      input_pos = 8'($urandom);
      if ($urandom_range(0, 1) == 1) switch_hit = switch_hit ^ (8'h01 << $urandom_range(0, 7));
      tick();
      n_checks++; if (game_state !== m_state) begin n_fail++; $display("FAIL rnd_state: cyc %0d actual %b expected %b", i, game_state, m_state); end
      n_checks++; if (cmole !== m_cmole) begin n_fail++; $display("FAIL rnd_cmole: cyc %0d actual %h expected %h", i, cmole, m_cmole); end
      n_checks++; if (molehit !== m_molehit) begin n_fail++; $display("FAIL rnd_molehit: cyc %0d actual %h expected %h", i, molehit, m_molehit); end
      n_checks++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL rnd_score: cyc %0d actual %0d expected %0d", i, score, m_score); end
      n_checks++; if (streak !== 4'(m_streak)) begin n_fail++; $display("FAIL rnd_streak: cyc %0d actual %0d expected %0d", i, streak, m_streak); end
      n_checks++; if (misses !== 8'(m_misses)) begin n_fail++; $display("FAIL rnd_misses: cyc %0d actual %0d expected %0d", i, misses, m_misses); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; gamestart = 1'b0; gameend = 1'b0;
    input_pos = 8'h00; switch_hit = 8'h00;
    test_reset();
    test_single_hit();
    test_double_hit();
    test_bonus();
    test_miss();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_score_tracker.md
MULTI_SCORE_TRACKER -- requirements
Module: multi_score_tracker

Interface
REQ-001 SHALL have parameter NUM_HOLES, default 8: number of mole holes and switches.
REQ-002 SHALL have parameter SCORE_W, default 8: width of score and misses counters.
REQ-003 SHALL have parameter STREAK_W, default 4: width of streak counter.
REQ-004 SHALL have parameter BONUS_THRESH, default 3: streak value at or above which each hit earns +1 bonus.
REQ-005 SHALL have port CLK100MHZ  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  one-cycle strobe: new mole pattern valid on input_pos.
REQ-008 SHALL have port gamestart  in  1  level; high = game running.
REQ-009 SHALL have port gameend  in  1  level; high = round time expired.
REQ-010 SHALL have port input_pos  in  NUM_HOLES  new mole pattern, one bit per hole.
REQ-011 SHALL have port switch_hit  in  NUM_HOLES  synchronised switch levels.
REQ-012 SHALL have port cmole  out  NUM_HOLES  moles currently up (to display).
REQ-013 SHALL have port molehit  out  NUM_HOLES  one-cycle pulse, holes hit this evaluation.
REQ-014 SHALL have port score  out  SCORE_W  current score.
REQ-015 SHALL have port streak  out  STREAK_W  consecutive clean hits.
REQ-016 SHALL have port misses  out  SCORE_W  switch rises on empty holes this game.
REQ-017 SHALL have port game_state  out  2  IDLE=00, PLAY=01, DONE=10.

Function
REQ-018 SHALL run FSM: IDLE->PLAY when gamestart=1; PLAY->DONE when gameend=1; PLAY or DONE->IDLE when gamestart=0 (priority over gameend).
REQ-019 SHALL, on IDLE->PLAY transition, clear score, streak, misses, cmole, molehit.
REQ-020 SHALL detect rises as rise = switch_hit & ~sw_prev, sw_prev registered every cycle in all states; only rises count, held switches never re-score.
REQ-021 SHALL, in PLAY with enable=1: cmole <= input_pos, molehit <= 0, discard that cycle's rises (no hit, no miss); if old cmole != 0 (escaped mole) clear streak.
REQ-022 SHALL, in PLAY with enable=0: hits = rise & cmole, miss = rise & ~cmole; cmole <= cmole & ~hits; molehit <= hits; misses += popcount(miss), saturating.
REQ-023 SHALL count all simultaneous hits: score += popcount(hits) + bonus, bonus = popcount(hits) if pre-update streak >= BONUS_THRESH, else 0.
REQ-024 SHALL add popcount(hits) to streak, saturating at 2^STREAK_W-1.
REQ-025 SHALL compute score update at SCORE_W+2 bits then clamp to [0, 2^SCORE_W-1]; no wrap-around.
REQ-026 SHALL, in DONE and IDLE, hold cmole=0 and molehit=0, freeze score/streak/misses, ignore switches and enable.
REQ-027 SHALL produce all outputs from registers; latency switch rise -> molehit/score = 1 cycle.

Reset
REQ-028 SHALL, when reset=1 at clock edge, set game_state=IDLE, cmole=0, molehit=0, score=0, streak=0, misses=0, sw_prev=all-ones, regardless of state (including mid-PLAY).
REQ-029 SHALL give reset priority over gamestart, gameend, enable.

Configuration
REQ-030 SHALL, with SCORE_MISS_PENALTY_EN defined, subtract popcount(miss) from score (same-cycle net with hits, clamped at 0) and clear streak on any miss (streak = popcount(hits) if hits same cycle, else 0).
REQ-031 SHALL, without SCORE_MISS_PENALTY_EN, leave score and streak unaffected by misses; misses counter still updates.

Verification (NUM_HOLES=8, SCORE_W=8, STREAK_W=4, BONUS_THRESH=3)
REQ-032 SHALL test: PLAY, enable with input_pos=0x24, rise sw2, hold 10 cycles -> molehit=0x04 for 1 cycle, score=1, cmole=0x20, no further increments.
REQ-033 SHALL test: cmole=0x24, sw2 and sw5 rise same cycle -> molehit=0x24, score+2, cmole=0x00, streak+2.
REQ-034 SHALL test: streak=3, score=10, one hit -> score=12, streak=4; enable arriving with cmole=0x01 -> streak=0.
REQ-035 SHALL test: score=0, rise on empty hole -> misses=1; with SCORE_MISS_PENALTY_EN score=0, streak=0; without, score and streak unchanged.
REQ-036 SHALL test: score=254, two simultaneous hits -> score=255 (saturate); gameend=1 -> DONE, cmole=0, later rises ignored.
REQ-037 SHALL test: reset=1 mid-PLAY with score=5 -> next cycle all outputs 0, game_state=00; held switch after reset produces no hit.
